// File: rtl/uart_rx_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fsm_ctrl
// Brief    : UART receive frame controller: start detect, bit pacing, LSB-first
//            deserialization, parity/stop checking and result strobes.
//            Optional macro UART_RX_BREAK_DETECT_EN adds break detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fsm_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rx_in,
    input  logic               sampled_data,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic               data_sample_en,
    output logic [PRESC_W-1:0] edge_count,
    output logic [PRESC_W-1:0] prescale_q,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               par_err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic               stp_err,
    output logic               busy,
    output logic               break_det
`else
    output logic               stp_err,
    output logic               busy
`endif
);

    localparam int                    c_BCNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_BCNT_W-1:0]   c_LAST_BIT  = c_BCNT_W'(DATA_W - 1);
    localparam logic [PRESC_W-1:0]    c_PRESC_DEF = PRESC_W'(8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PRESC_W-1:0]  r_edge_cnt;
    logic [PRESC_W-1:0]  r_presc_q;
    logic [PRESC_W-1:0]  w_presc_legal;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_par_en;
    logic                r_par_typ;
    logic                r_par_bad;
    logic                r_valid;
    logic                r_par_err;
    logic                r_stp_err;
    logic                w_active;
    logic                w_bit_end;
    logic                w_par_exp;
    logic                w_start;
    logic                w_brk_block;

    assign w_active  = (r_state != S_IDLE);
    assign w_bit_end = w_active && (r_edge_cnt == (r_presc_q - PRESC_W'(1)));
    assign w_par_exp = r_par_typ ? ~^r_data : ^r_data;
    assign w_start   = (r_state == S_IDLE) && (w_state_nxt == S_START);

    always_comb begin
        w_presc_legal = c_PRESC_DEF;
        case (prescale)
            PRESC_W'(4), PRESC_W'(8), PRESC_W'(16), PRESC_W'(32): w_presc_legal = prescale;
            default:                                              w_presc_legal = c_PRESC_DEF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!rx_in && !w_brk_block) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    // A high majority at the end of the start bit is a glitch.
                    w_state_nxt = sampled_data ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_LAST_BIT)) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_presc_q  <= c_PRESC_DEF;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;

            if (!w_active) begin
                r_edge_cnt <= '0;
            end else if (w_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
            end

            if (w_start) begin
                r_presc_q <= w_presc_legal;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_par_bad <= 1'b0;
            end

            if (w_bit_end) begin
                case (r_state)
                    S_START: r_bit_cnt <= '0;
                    S_DATA: begin
                        r_data    <= {sampled_data, r_data[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
                    end
                    S_PARITY: r_par_bad <= (sampled_data != w_par_exp);
                    S_STOP: begin
                        r_stp_err <= ~sampled_data;
                        r_par_err <= r_par_bad;
                        r_valid   <= sampled_data & ~r_par_bad;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic               r_brk_wait;
    logic               r_par_one;
    logic               r_break;
    logic [PRESC_W-1:0] r_hi_cnt;
    logic               w_brk_hit;

    assign w_brk_hit   = (r_state == S_STOP) && w_bit_end && (r_data == '0)
                         && !r_par_one && !sampled_data;
    assign w_brk_block = r_brk_wait;
    assign break_det   = r_break;

    // After a break, the line must stay high for a whole bit before re-arming.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_brk_wait <= 1'b0;
            r_par_one  <= 1'b0;
            r_break    <= 1'b0;
            r_hi_cnt   <= '0;
        end else begin
            r_break <= w_brk_hit;
            if (w_start) begin
                r_par_one <= 1'b0;
            end else if ((r_state == S_PARITY) && w_bit_end) begin
                r_par_one <= sampled_data;
            end
            if (w_brk_hit) begin
                r_brk_wait <= 1'b1;
                r_hi_cnt   <= '0;
            end else if (r_brk_wait) begin
                if (!rx_in) begin
                    r_hi_cnt <= '0;
                end else if (r_hi_cnt == (r_presc_q - PRESC_W'(1))) begin
                    r_brk_wait <= 1'b0;
                    r_hi_cnt   <= '0;
                end else begin
                    r_hi_cnt <= r_hi_cnt + PRESC_W'(1);
                end
            end
        end
    end
`else
    assign w_brk_block = 1'b0;
`endif

    assign data_sample_en = w_active;
    assign busy           = w_active;
    assign edge_count     = r_edge_cnt;
    assign prescale_q     = r_presc_q;
    assign P_DATA         = r_data;
    assign data_valid     = r_valid;
    assign par_err        = r_par_err;
    assign stp_err        = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fsm_ctrl
// Brief    : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized frames against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm_ctrl;

    localparam int DATA_W  = 8;
    localparam int PRESC_W = 6;

    logic               CLK = 1'b0;
    logic               RST;
    logic               rx_in;
    logic               sampled_data;
    logic [PRESC_W-1:0] prescale;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic               data_sample_en;
    logic [PRESC_W-1:0] edge_count;
    logic [PRESC_W-1:0] prescale_q;
    logic [DATA_W-1:0]  P_DATA;
    logic               data_valid;
    logic               par_err;
    logic               stp_err;
    logic               busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic               break_det;
`endif

    uart_rx_fsm_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .rx_in          (rx_in),
        .sampled_data   (sampled_data),
        .prescale       (prescale),
        .PAR_EN         (PAR_EN),
        .PAR_TYP        (PAR_TYP),
        .data_sample_en (data_sample_en),
        .edge_count     (edge_count),
        .prescale_q     (prescale_q),
        .P_DATA         (P_DATA),
        .data_valid     (data_valid),
        .par_err        (par_err),
`ifdef UART_RX_BREAK_DETECT_EN
        .stp_err        (stp_err),
        .busy           (busy),
        .break_det      (break_det)
`else
        .stp_err        (stp_err),
        .busy           (busy)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         presc;
        bit         par_en;
        bit         par_typ;
        logic [7:0] data;
        bit         par_bit;
        bit         stop_bit;
        int         chg_presc;
        int         exp_p;
        bit         exp_dv;
        bit         exp_pe;
        bit         exp_se;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff_presc(input int p);
        return (p == 4 || p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    // Line level of frame bit j (0 = start bit); past the stop bit the line idles high.
    function automatic bit fbit(input vec_t v, input int j);
        int last;
        last = DATA_W + 1 + (v.par_en ? 1 : 0);
        if (j == 0)                          return 1'b0;
        if (j >= 1 && j <= DATA_W)           return v.data[j-1];
        if (v.par_en && j == DATA_W + 1)     return v.par_bit;
        if (j == last)                       return v.stop_bit;
        return 1'b1;
    endfunction

    // t counts clock edges from the edge that sees the start bit; the sampler's
    // majority for a bit is presented from the edge after the bit begins.
    task automatic run_frame(input vec_t v, input bit nowait, input string tag);
        int P, T;
        int dv_n, pe_n, se_n, dv_t, pe_t, se_t, ec_bad, act_bad;
        logic busy_end;
        P = v.exp_p;
        T = (DATA_W + (v.par_en ? 1 : 0) + 2) * P;
        dv_n = 0; pe_n = 0; se_n = 0; dv_t = -1; pe_t = -1; se_t = -1;
        ec_bad = 0; act_bad = 0; busy_end = 1'bx;
        for (int t = 0; t <= T + 1; t++) begin
            if (!(t == 0 && nowait)) @(negedge CLK);
            if (t > 0) begin
                if (data_valid === 1'b1) begin dv_n++; dv_t = t; end
                if (par_err === 1'b1)    begin pe_n++; pe_t = t; end
                if (stp_err === 1'b1)    begin se_n++; se_t = t; end
                if (t <= T) begin
                    if (edge_count !== PRESC_W'((t - 1) % P)) ec_bad++;
                    if (busy !== 1'b1 || data_sample_en !== 1'b1 || prescale_q !== PRESC_W'(P)) act_bad++;
                end else begin
                    busy_end = busy;
                end
            end
            if (t <= T) begin
                if (t == 0) begin
                    prescale = PRESC_W'(v.presc);
                    PAR_EN   = v.par_en;
                    PAR_TYP  = v.par_typ;
                end
                if (v.chg_presc != 0 && t == 3 * P) begin
                    prescale = PRESC_W'(v.chg_presc);
                    PAR_EN   = ~v.par_en;
                    PAR_TYP  = ~v.par_typ;
                end
                rx_in        = fbit(v, t / P);
                sampled_data = (t == 0) ? 1'b0 : fbit(v, (t - 1) / P);
            end else begin
                rx_in        = 1'b1;
                sampled_data = 1'b1;
            end
        end
        chk({tag, " dv_count"}, 64'(dv_n), 64'(v.exp_dv));
        chk({tag, " pe_count"}, 64'(pe_n), 64'(v.exp_pe));
        chk({tag, " se_count"}, 64'(se_n), 64'(v.exp_se));
        if (v.exp_dv) chk({tag, " dv_time"}, 64'(dv_t), 64'(T + 1));
        if (v.exp_pe) chk({tag, " pe_time"}, 64'(pe_t), 64'(T + 1));
        if (v.exp_se) chk({tag, " se_time"}, 64'(se_t), 64'(T + 1));
        chk({tag, " P_DATA"}, 64'(P_DATA), 64'(v.data));
        chk({tag, " edge_count_track"}, 64'(ec_bad), 64'd0);
        chk({tag, " busy_en_presc_track"}, 64'(act_bad), 64'd0);
        chk({tag, " busy_after"}, 64'(busy_end), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            rx_in        = 1'b1;
            sampled_data = 1'b1;
        end
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        int pulses, good_par, ones;
        int plist[7];
        plist = '{4, 8, 16, 32, 10, 0, 63};

        // Frame vectors: presc, par_en, par_typ, data, par_bit, stop, chg, eff_p, dv, pe, se
        tbl[0] = '{8,  0, 0, 8'hA5, 0, 1, 0,  8,  1, 0, 0};
        tbl[1] = '{16, 1, 0, 8'h3C, 1, 1, 0,  16, 0, 1, 0};
        tbl[2] = '{32, 1, 1, 8'h01, 0, 0, 0,  32, 0, 0, 1};
        tbl[3] = '{10, 0, 0, 8'h5A, 0, 1, 0,  8,  1, 0, 0};
        tbl[4] = '{4,  1, 0, 8'hFF, 0, 1, 0,  4,  1, 0, 0};
        tbl[5] = '{8,  1, 1, 8'h80, 1, 0, 16, 8,  0, 1, 1};

        RST = 1'b1; rx_in = 1'b1; sampled_data = 1'b1;
        prescale = PRESC_W'(16); PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst sample_en", 64'(data_sample_en), 64'd0);
        chk("rst edge_count", 64'(edge_count), 64'd0);
        chk("rst prescale_q", 64'(prescale_q), 64'd8);
        chk("rst P_DATA", 64'(P_DATA), 64'd0);
        chk("rst strobes", 64'({data_valid, par_err, stp_err}), 64'd0);
        RST = 1'b0;
        idle_cycles(3);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], 1'b0, $sformatf("vec%0d", i));
            idle_cycles(2);
        end

        // Frame after a mid-frame prescale change uses the new ratio.
        rv = '{16, 0, 0, 8'hC3, 0, 1, 0, 16, 1, 0, 0};
        run_frame(rv, 1'b0, "after_chg");

        // Start glitch: line low for 3 cycles, majority reports high.
        @(negedge CLK);
        prescale = PRESC_W'(8); PAR_EN = 1'b0;
        rx_in = 1'b0; sampled_data = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge CLK);
            if (t == 3) rx_in = 1'b1;
            if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) pulses++;
            if (t == 8) chk("glitch busy_mid", 64'(busy), 64'd1);
            if (t == 9) chk("glitch busy_end", 64'(busy), 64'd0);
        end
        chk("glitch pulses", 64'(pulses), 64'd0);

        // Reset during data bit 4, then a clean 0x5A frame.
        @(negedge CLK);
        prescale = PRESC_W'(8); PAR_EN = 1'b0;
        rx_in = 1'b0; sampled_data = 1'b0;
        for (int t = 1; t <= 43; t++) begin
            @(negedge CLK);
            rx_in        = (t / 8 == 0) ? 1'b0 : 1'b1;
            sampled_data = ((t - 1) / 8 == 0) ? 1'b0 : 1'b1;
        end
        chk("pre_rst busy", 64'(busy), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst P_DATA", 64'(P_DATA), 64'd0);
        chk("midrst edge_count", 64'(edge_count), 64'd0);
        chk("midrst outs", 64'({data_valid, par_err, stp_err, data_sample_en}), 64'd0);
        RST = 1'b0;
        idle_cycles(12);
        rv = '{8, 0, 0, 8'h5A, 0, 1, 0, 8, 1, 0, 0};
        run_frame(rv, 1'b0, "post_rst");

        // Randomized frames, some back-to-back, against the frame-level model.
        for (int n = 0; n < 30; n++) begin
            int gap;
            rv.presc    = plist[$urandom_range(0, 6)];
            rv.par_en   = 1'($urandom_range(0, 1));
            rv.par_typ  = 1'($urandom_range(0, 1));
            rv.data     = 8'($urandom);
            ones        = $countones(rv.data);
            good_par    = rv.par_typ ? ((ones % 2 == 0) ? 1 : 0) : ones % 2;
            rv.par_bit  = ($urandom_range(0, 3) == 0) ? 1'(1 - good_par) : 1'(good_par);
            rv.stop_bit = ($urandom_range(0, 3) != 0);
            rv.chg_presc = ($urandom_range(0, 3) == 0) ? 16 : 0;
            rv.exp_p    = eff_presc(rv.presc);
            rv.exp_pe   = rv.par_en && (int'(rv.par_bit) != good_par);
            rv.exp_se   = !rv.stop_bit;
            rv.exp_dv   = !rv.exp_pe && !rv.exp_se;
            gap = $urandom_range(0, 2);
            if (gap == 0) begin
                run_frame(rv, 1'b1, $sformatf("rnd%0d", n));
            end else begin
                idle_cycles(gap - 1);
                run_frame(rv, 1'b0, $sformatf("rnd%0d", n));
            end
        end

        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
